// File: rtl/ark_lane_stage.sv
// AddRoundKey stage: captures state and round key on a valid/ready handshake,
// XORs them LANE_W bits per cycle and presents the block on a valid/ready output.
module ark_lane_stage #(
    parameter int DATA_W    = 128,
    parameter int LANE_W    = 32,
    parameter int MAX_ROUND = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ori_data_in,
    input  logic [DATA_W-1:0] new_data_in,
    input  logic [DATA_W-1:0] key_in,
    input  logic [3:0]        round_in,
    input  logic              ark_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        round_out,
    output logic              round_err,
    output logic              busy
);

    localparam int BEATS = DATA_W / LANE_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (DATA_W % LANE_W != 0) begin : g_bad_lane
        $error("ark_lane_stage: DATA_W must be a multiple of LANE_W");
    end

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t            state_q;
    logic [BW-1:0]     beat_q;
    logic [DATA_W-1:0] src_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] res_q;
    logic [3:0]        round_q;
    logic              en_q;
    logic              err_q;
    logic              accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign data_out  = res_q;
    assign round_out = round_q;
    assign round_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            src_q   <= '0;
            key_q   <= '0;
            res_q   <= '0;
            round_q <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            // A DONE-state accept doubles as the output handshake for the previous block.
            state_q <= PROC;
            beat_q  <= '0;
            src_q   <= (round_in == 4'd0) ? ori_data_in : new_data_in;
            key_q   <= key_in;
            round_q <= round_in;
            en_q    <= ark_en;
            err_q   <= (int'(round_in) > MAX_ROUND);
        end else begin
            case (state_q)
                PROC: begin
                    res_q[int'(beat_q)*LANE_W +: LANE_W] <= en_q ?
                        (src_q[int'(beat_q)*LANE_W +: LANE_W] ^ key_q[int'(beat_q)*LANE_W +: LANE_W]) :
                        '0;
                    if (beat_q == LAST_BEAT) begin
                        state_q <= DONE;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ark_lane_stage.sv
// Directed bench for ark_lane_stage: vector table plus hand-written handshake,
// back-pressure, reset-abort and lane-width sequences.
module tb_ark_lane_stage;

    logic         clk;
    logic         rst;
    logic         in_valid, in_valid_w128, in_valid_w8;
    logic         out_ready, out_ready_w128, out_ready_w8;
    logic [127:0] ori_data_in, new_data_in, key_in;
    logic [3:0]   round_in;
    logic         ark_en;

    logic         in_ready, out_valid, round_err, busy;
    logic [127:0] data_out;
    logic [3:0]   round_out;

    logic         in_ready_w128, out_valid_w128, round_err_w128, busy_w128;
    logic [127:0] data_out_w128;
    logic [3:0]   round_out_w128;

    logic         in_ready_w8, out_valid_w8, round_err_w8, busy_w8;
    logic [127:0] data_out_w8;
    logic [3:0]   round_out_w8;

    int checks = 0;
    int errors = 0;

    ark_lane_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ori_data_in(ori_data_in), .new_data_in(new_data_in), .key_in(key_in),
        .round_in(round_in), .ark_en(ark_en), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .round_out(round_out),
        .round_err(round_err), .busy(busy)
    );

    ark_lane_stage #(.LANE_W(128)) dut_w128 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w128), .in_ready(in_ready_w128),
        .ori_data_in(ori_data_in), .new_data_in(new_data_in), .key_in(key_in),
        .round_in(round_in), .ark_en(ark_en), .out_valid(out_valid_w128),
        .out_ready(out_ready_w128), .data_out(data_out_w128), .round_out(round_out_w128),
        .round_err(round_err_w128), .busy(busy_w128)
    );

    ark_lane_stage #(.LANE_W(8)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w8), .in_ready(in_ready_w8),
        .ori_data_in(ori_data_in), .new_data_in(new_data_in), .key_in(key_in),
        .round_in(round_in), .ark_en(ark_en), .out_valid(out_valid_w8),
        .out_ready(out_ready_w8), .data_out(data_out_w8), .round_out(round_out_w8),
        .round_err(round_err_w8), .busy(busy_w8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ori;
        logic [127:0] nw;
        logic [127:0] key;
        logic [3:0]   rnd;
        logic         en;
        logic [127:0] exp_d;
        logic [3:0]   exp_r;
        logic         exp_e;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ori_data_in = v.ori;
        new_data_in = v.nw;
        key_in      = v.key;
        round_in    = v.rnd;
        ark_en      = v.en;
    endtask

    // Called at a negedge right after the accept edge; returns edges until out_valid.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept_main(input vec_t v);
        drive(v);
        in_valid = 1'b1;
        chk("in_ready_before_accept", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        new_data_in = '1;
        ori_data_in = '1;
        key_in      = '1;
        round_in    = 4'd7;
        ark_en      = 1'b1;
    endtask

    initial begin
        int n, n8, n128, rises;
        logic [127:0] held;

        vt[0] = '{128'h00112233445566778899aabbccddeeff, 128'hdeadbeefcafef00d123456789abcdef0,
                  128'h000102030405060708090a0b0c0d0e0f, 4'd0, 1'b1,
                  128'h00102030405060708090a0b0c0d0e0f0, 4'd0, 1'b0};
        vt[1] = '{128'h0, {16{8'hff}}, {16{8'h0f}}, 4'd5, 1'b1, {16{8'hf0}}, 4'd5, 1'b0};
        vt[2] = '{{16{8'h11}}, {16{8'h22}}, {16{8'h33}}, 4'd3, 1'b0, 128'h0, 4'd3, 1'b0};
        vt[3] = '{{16{8'hff}}, 128'h0123456789abcdeffedcba9876543210, 128'h0, 4'd11, 1'b1,
                  128'h0123456789abcdeffedcba9876543210, 4'd11, 1'b1};
        vt[4] = '{128'h0, {16{8'haa}}, {16{8'h55}}, 4'd10, 1'b1, {16{8'hff}}, 4'd10, 1'b0};
        vt[5] = '{128'h0, {16{8'hff}}, 128'h13579bdf2468ace00f1e2d3c4b5a6978, 4'd0, 1'b1,
                  128'h13579bdf2468ace00f1e2d3c4b5a6978, 4'd0, 1'b0};
        vt[6] = '{128'h0, 128'h1, 128'h80000000000000000000000000000000, 4'd15, 1'b1,
                  128'h80000000000000000000000000000001, 4'd15, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; in_valid_w128 = 1'b0; in_valid_w8 = 1'b0;
        out_ready = 1'b0; out_ready_w128 = 1'b0; out_ready_w8 = 1'b0;
        ori_data_in = '0; new_data_in = '0; key_in = '0; round_in = '0; ark_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_data_out", data_out, 128'h0);
        chk("reset_round_out", round_out, 4'd0);
        chk("reset_round_err", round_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            accept_main(vt[i]);
            chk("busy_in_proc", busy, 1'b1);
            chk("in_ready_in_proc", in_ready, 1'b0);
            wait_valid(n);
            chk($sformatf("latency_v%0d", i), n, 4);
            chk($sformatf("data_v%0d", i), data_out, vt[i].exp_d);
            chk($sformatf("round_v%0d", i), round_out, vt[i].exp_r);
            chk($sformatf("err_v%0d", i), round_err, vt[i].exp_e);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("idle_after_pop_v%0d", i), {busy, out_valid}, 2'b00);
            chk($sformatf("data_held_idle_v%0d", i), data_out, vt[i].exp_d);
        end

        // back-pressure in DONE, then a simultaneous pop and accept
        accept_main(vt[1]);
        wait_valid(n);
        chk("bp_latency", n, 4);
        drive(vt[3]);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_data", data_out, vt[1].exp_d);
            chk("bp_round", round_out, vt[1].exp_r);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_out_valid_drop", out_valid, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        wait_valid(n);
        chk("b2b_latency", n, 4);
        chk("b2b_data", data_out, vt[3].exp_d);
        chk("b2b_err", round_err, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // reset two cycles into PROC aborts the block
        accept_main(vt[0]);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_async_valid", out_valid, 1'b0);
        chk("abort_async_data", data_out, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_data", data_out, 128'h0);
        chk("abort_round", round_out, 4'd0);
        rises = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid || busy) rises++;
        end
        chk("abort_no_output", rises, 0);

        // lane-width variants run the FIPS-197 round-0 vector
        drive(vt[0]);
        in_valid_w128 = 1'b1;
        in_valid_w8   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_w128 = 1'b0;
        in_valid_w8   = 1'b0;
        held = '0;
        n8 = -1; n128 = -1;
        for (int c = 0; c <= 30; c++) begin
            if (out_valid_w128 && n128 < 0) n128 = c;
            if (out_valid_w8 && n8 < 0) n8 = c;
            @(negedge clk);
        end
        chk("w128_latency", n128, 1);
        chk("w8_latency", n8, 16);
        chk("w128_data", data_out_w128, vt[0].exp_d);
        chk("w8_data", data_out_w8, vt[0].exp_d);
        chk("w8_round_err", round_err_w8, 1'b0);
        out_ready_w128 = 1'b1;
        out_ready_w8   = 1'b1;
        @(negedge clk);
        chk("w_variants_idle", {out_valid_w128, out_valid_w8}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
